// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: debounces mode/inc buttons, runs RUN/SET_HOUR/SET_MIN,
// auto-repeats inc and emits load strobes. Optional idle abandon enabled by `define TIME_SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic       load_h,
  output logic       load_m,
  output logic       sec_clr,
  output logic [1:0] mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2
  } state_e;

  // Index 0 = mode button, index 1 = inc button; all levels active-high after the synchronizer.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q, acc_q, acc_prev_q, press_q;
  logic [DB_W-1:0] db_cnt_q [2];

  assign btn_raw = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= ~btn_raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      press_q    <= acc_q & ~acc_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          acc_q[i]    <= ~acc_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Hold counter restarts at 1 after each press/repeat; the compare target switches from delay to rate.
  logic [RP_W-1:0] hold_cnt_q;
  logic            hold_act_q, rep_phase_q;
  logic            rep_ev;

  assign rep_ev = acc_q[1] & hold_act_q &
                  (hold_cnt_q == (rep_phase_q ? RP_W'(REPEAT_RATE) : RP_W'(REPEAT_DELAY)));

  always_ff @(posedge clk) begin
    if (!reset_n || !acc_q[1]) begin
      hold_cnt_q  <= '0;
      hold_act_q  <= 1'b0;
      rep_phase_q <= 1'b0;
    end else if (press_q[1]) begin
      hold_cnt_q  <= RP_W'(1);
      hold_act_q  <= 1'b1;
      rep_phase_q <= 1'b0;
    end else if (hold_act_q) begin
      if (rep_ev) begin
        hold_cnt_q  <= RP_W'(1);
        rep_phase_q <= 1'b1;
      end else begin
        hold_cnt_q  <= hold_cnt_q + 1'b1;
      end
    end
  end

  logic   mode_ev, inc_ev, timeout_hit;
  state_e state_q;
  logic [4:0] edit_h_q;
  logic [5:0] edit_m_q;
  logic       load_h_q, load_m_q, sec_clr_q;

  assign mode_ev = press_q[0];
  assign inc_ev  = press_q[1] | rep_ev;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q;

  assign timeout_hit = (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || state_q == S_RUN || mode_ev || inc_ev) idle_q <= '0;
    else if (!timeout_hit) idle_q <= idle_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Mode events take priority over inc events arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      edit_h_q  <= '0;
      edit_m_q  <= '0;
      load_h_q  <= 1'b0;
      load_m_q  <= 1'b0;
      sec_clr_q <= 1'b0;
    end else begin
      load_h_q  <= 1'b0;
      load_m_q  <= 1'b0;
      sec_clr_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (mode_ev) begin
            edit_h_q <= cur_hour;
            edit_m_q <= cur_min;
            state_q  <= S_HOUR;
          end
        end
        S_HOUR: begin
          if (mode_ev) state_q <= S_MIN;
          else if (inc_ev) edit_h_q <= (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
          else if (timeout_hit) state_q <= S_RUN;
        end
        S_MIN: begin
          if (mode_ev) begin
            state_q   <= S_RUN;
            load_h_q  <= 1'b1;
            load_m_q  <= 1'b1;
            sec_clr_q <= 1'b1;
          end else if (inc_ev) begin
            edit_m_q <= (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
          end else if (timeout_hit) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign set_hour = edit_h_q;
  assign set_min  = edit_m_q;
  assign load_h   = load_h_q;
  assign load_m   = load_m_q;
  assign sec_clr  = sec_clr_q;
  assign mode     = state_q;

endmodule
